// File: rtl/gt_check_pkg.sv
// Shared types and helpers for the greater-than sweep checker.
package gt_check_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int unsigned pair_count(input int unsigned n);
    return 32'd1 << (2 * n);
  endfunction

endpackage

// File: rtl/gt_sweep_gen.sv
// Operand pair generator: a inner loop, b outer, each pair held SETTLE cycles.
module gt_sweep_gen #(
  parameter int N      = 2,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  input  logic         hold,
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  output logic         sample,
  output logic         last
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;

  assign a      = a_q;
  assign b      = b_q;
  assign sample = en && (cnt_q == CW'(SETTLE - 1));
  assign last   = sample && (&a_q) && (&b_q);

  always_comb begin
    cnt_d = cnt_q;
    a_d   = a_q;
    b_d   = b_q;
    if (clear) begin
      cnt_d = '0;
      a_d   = '0;
      b_d   = '0;
    end else if (sample) begin
      cnt_d = '0;
      // the final or a stopping pair stays on the bus
      if (!last && !hold) begin
        a_d = a_q + N'(1);
        if (&a_q) b_d = b_q + N'(1);
      end
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      a_q   <= a_d;
      b_q   <= b_d;
    end
  end

endmodule

// File: rtl/gt_sweep_checker.sv
// Exhaustive self-check of an N-bit greater-than comparator.
// GT_CHECK_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module gt_sweep_checker
  import gt_check_pkg::*;
#(
  parameter int N      = 2,
  parameter int SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic [N-1:0]   a_o,
  output logic [N-1:0]   b_o,
  input  logic           gt_i,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2*N:0]   err_cnt,
  output logic           fail_vld,
  output logic [N-1:0]   fail_a,
  output logic [N-1:0]   fail_b
);

  localparam int          EW    = 2 * N + 1;
  localparam int unsigned PAIRS = pair_count(N);

  state_t         state_q, state_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           pass_q, pass_d;
  logic [EW-1:0]  err_q, err_d;
  logic           fv_q, fv_d;
  logic [N-1:0]   fa_q, fa_d;
  logic [N-1:0]   fb_q, fb_d;

  logic start_ok;
  logic sample;
  logic last;
  logic mismatch;
  logic stop;

  assign start_ok = start && (state_q != DRIVE);
  assign mismatch = sample && (gt_i != (a_o > b_o));

`ifdef GT_CHECK_STOP_ON_FAIL_EN
  assign stop = mismatch;
`else
  assign stop = 1'b0;
`endif

  gt_sweep_gen #(
    .N      (N),
    .SETTLE (SETTLE)
  ) u_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start_ok),
    .en     (state_q == DRIVE),
    .hold   (stop),
    .a      (a_o),
    .b      (b_o),
    .sample (sample),
    .last   (last)
  );

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          state_d = DRIVE;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          fv_d    = 1'b0;
          fa_d    = '0;
          fb_d    = '0;
        end
      end
      DRIVE: begin
        if (mismatch) begin
          if (err_q != EW'(PAIRS)) err_d = err_q + EW'(1);
          if (!fv_q) begin
            fv_d = 1'b1;
            fa_d = a_o;
            fb_d = b_o;
          end
        end
        if (last || stop) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fa_q    <= '0;
      fb_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign fail_vld = fv_q;
  assign fail_a   = fa_q;
  assign fail_b   = fb_q;

endmodule
